fixp_acc_engine: RTL and testbench
==================================

// Module: fixp_acc_engine
// PURPOSE
//  Upstream read-modify-write engine for the fixed-point accumulator cache (fix_acc_cache).
//  - Accepts a valid/ready stream of (bin, vector) samples.
//  - For each sample: looks up bin in the cache, adds the sample lane-wise with signed
//    saturation, and writes the result back through the cache port.
//  - Owns cache clear (set_zero); reports sample and saturation counters to CSR logic.
// PARAMETERS
//  DEPTH       32   number of accumulator bins; AW = clog2(DEPTH) (5 at default)
//  DATA_W      128  vector width; equals the cache PRE_REG_WIDTH
//  LANE_W      32   signed fixed-point lane width; DATA_W % LANE_W == 0, LANES = DATA_W/LANE_W
// PORTS
//  clk            in   1       clock
//  rstn           in   1       reset
//  clr            in   1       1-cycle pulse: zero all bins and counters
//  s_valid        in   1       input sample valid
//  s_ready        out  1       engine can take a sample
//  s_bin          in   AW      target bin
//  s_data         in   DATA_W  LANES packed signed lanes, lane0 = [LANE_W-1:0]
//  cache_set_zero out  1       to cache set_zero
//  cache_r_req    out  1       to cache r_req
//  cache_r_addr   out  AW      to cache r_addr
//  cache_req_hit  in   1       from cache req_hit (combinational on r_addr)
//  cache_r_data   in   DATA_W  from cache r_data (hot line contents)
//  cache_w_req    out  1       to cache w_req
//  cache_w_addr   out  AW      to cache w_addr
//  cache_w_data   out  DATA_W  to cache w_data
//  cache_w_ready  in   1       from cache w_ready (cache idle)
//  busy           out  1       a sample is in flight
//  acc_count      out  32      samples fully accumulated since reset/clr; wraps at 2^32
//  sat_count      out  32      lanes clipped since reset/clr; saturates at 0xFFFFFFFF
// BEHAVIOUR
//  Reset
//  - Reset is rstn, synchronous, active-low; clock is clk.
//  - During and after reset: state=IDLE, all outputs 0 except s_ready=1.
//    Counters 0; held sample discarded. Reset mid-operation drops the in-flight sample.
//  FSM
//  - IDLE:   s_ready=1. On s_valid, latch bin/data into hold regs -> LOOKUP.
//  - LOOKUP: cache_r_req=1, cache_r_addr=hold_bin.
//            Stay while !(cache_req_hit & cache_w_ready); a miss is fetched by the cache.
//            When hit & w_ready: sum_reg <= satadd(cache_r_data, hold_data) -> WRITE.
//  - WRITE:  cache_r_req=1, cache_w_req=1, r_addr=w_addr=hold_bin, w_data=sum_reg.
//            Single cycle. acc_count+1, sat_count += clipped lanes this sample -> IDLE.
//  - s_ready=0 in LOOKUP and WRITE; busy = (state != IDLE).
//  - cache_w_req is never asserted without cache_r_req; this makes the write update the hot line.
//  Throughput and latency
//  - Best case (hit) is 3 cycles per sample: accept, LOOKUP, WRITE.
//  - The result is visible in the cache 1 cycle after WRITE.
//  Arithmetic
//  - Each lane: a + b in LANE_W+1 bits, then clamp.
//    Above 2^(LANE_W-1)-1 -> 0x7FF..F; below -2^(LANE_W-1) -> 0x800..0.
//  - Each clamped lane counts 1 into sat_count; the count is clamped at max.
//  Clear
//  - clr in any state: cache_set_zero=1 for exactly the next cycle.
//  - Same edge: counters cleared; any in-flight sample dropped; state -> IDLE.
//  - s_ready=0 during the set_zero cycle. clr and s_valid together: clr wins, no sample taken.
//  Back-to-back samples to the same bin
//  - Allowed. The second sample's LOOKUP sees the hot-line value the first sample's WRITE
//    just produced, so no accumulation is lost.
//  Not checked
//  - An out-of-range s_bin (>= DEPTH when DEPTH is not a power of 2) is not checked.
//    Behaviour is whatever the cache does for that address.
// TESTING
//  1. Reset: rstn=0 3 cycles -> s_ready=1, busy=0, counters 0, no cache_r_req/w_req.
//  2. Hit accumulate: bin 3 gets data lanes {1,2,3,4} twice.
//     -> bin 3 reads {2,4,6,8}; acc_count=2; sat_count=0; 3 cycles per sample when hot.
//  3. Miss then hit: bin 3 gets {1,1,1,1}, then bin 7 gets {5,5,5,5}, then bin 3 gets {1,1,1,1}.
//     -> LOOKUP holds until hit & w_ready; final bin3={2,2,2,2}, bin7={5,5,5,5}.
//  4. Saturation: lane0 holds 0x7FFFFFF0 and is added 0x00000020 -> 0x7FFFFFFF.
//     lane1 holds 0x80000001 and is added 0xFFFFFFF0 -> 0x80000000; sat_count=2.
//  5. clr mid-LOOKUP during a miss -> cache_set_zero pulses 1 cycle; sample dropped;
//     acc_count=0; next sample of {9,9,9,9} yields exactly {9,9,9,9}.
//  6. Random stream of 10k samples across all 32 bins vs. a saturating scoreboard.
//     -> every bin matches; acc_count=10000.

Source files
------------

// File: rtl/fixp_acc_engine_if.sv
// Sample stream and cache port bundle for fixp_acc_engine.
//  slave  : engine side (takes samples, drives the cache request port)
//  master : environment side (sample source plus the accumulator cache)
//  s_valid/s_ready/s_bin/s_data      : sample stream, lane0 = s_data[LANE_W-1:0]
//  cache_set_zero                    : clear-all pulse to the cache
//  cache_r_req/cache_r_addr          : hot-line lookup request
//  cache_req_hit/cache_r_data        : hot-line hit flag and contents (combinational on r_addr)
//  cache_w_req/w_addr/w_data/w_ready : hot-line write-back port, w_ready = cache idle
interface fixp_acc_engine_if #(
    parameter int unsigned AW     = 5,
    parameter int unsigned DATA_W = 128
);
    logic              s_valid;
    logic              s_ready;
    logic [AW-1:0]     s_bin;
    logic [DATA_W-1:0] s_data;

    logic              cache_set_zero;
    logic              cache_r_req;
    logic [AW-1:0]     cache_r_addr;
    logic              cache_req_hit;
    logic [DATA_W-1:0] cache_r_data;
    logic              cache_w_req;
    logic [AW-1:0]     cache_w_addr;
    logic [DATA_W-1:0] cache_w_data;
    logic              cache_w_ready;

    modport slave (
        input  s_valid, s_bin, s_data,
        input  cache_req_hit, cache_r_data, cache_w_ready,
        output s_ready,
        output cache_set_zero, cache_r_req, cache_r_addr,
        output cache_w_req, cache_w_addr, cache_w_data
    );

    modport master (
        output s_valid, s_bin, s_data,
        output cache_req_hit, cache_r_data, cache_w_ready,
        input  s_ready,
        input  cache_set_zero, cache_r_req, cache_r_addr,
        input  cache_w_req, cache_w_addr, cache_w_data
    );
endinterface

// File: rtl/fixp_acc_engine.sv
// Read-modify-write engine in front of the fixed-point accumulator cache.
// Each accepted (bin, vector) sample is added lane-wise with signed saturation
// to the cached bin contents and written back to the hot line.
//  clk, rstn  : clock, synchronous active-low reset
//  clr        : one-cycle pulse, zeroes the cache (via cache_set_zero) and counters
//  bus        : sample stream + cache port (slave modport)
//  busy       : a sample is in flight
//  acc_count  : samples accumulated since reset/clr (wraps)
//  sat_count  : lanes clipped since reset/clr (saturates)
module fixp_acc_engine #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LANE_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    fixp_acc_engine_if.slave      bus,
    output logic                  busy,
    output logic [31:0]           acc_count,
    output logic [31:0]           sat_count
);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LANES = DATA_W / LANE_W;
    localparam int unsigned CW    = $clog2(LANES + 1);
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              accept_c, load_sum_c;

    logic [AW-1:0]     hold_bin_q;
    logic [DATA_W-1:0] hold_data_q;
    logic [DATA_W-1:0] sum_q, sum_c;
    logic [CW-1:0]     clip_q, clip_c;

    logic              s_ready_q, set_zero_q, r_req_q, w_req_q, busy_q;
    logic [CNT_W-1:0]  acc_count_q, sat_count_q;
    logic [CNT_W:0]    sat_sum_c;

    logic [LANE_W-1:0] lane_a, lane_b;
    logic [LANE_W:0]   lane_sum;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; clr overrides everything and drops the sample in flight
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        load_sum_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.s_valid && s_ready_q) begin
                    accept_c = 1'b1;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cache_req_hit && bus.cache_w_ready) begin
                    load_sum_c = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d    = IDLE;
            accept_c   = 1'b0;
            load_sum_c = 1'b0;
        end
    end

    // Lane-wise add in LANE_W+1 bits; a carry/sign disagreement means overflow
    always_comb begin
        sum_c    = '0;
        clip_c   = '0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_a   = bus.cache_r_data[i*LANE_W +: LANE_W];
            lane_b   = hold_data_q[i*LANE_W +: LANE_W];
            lane_sum = {lane_a[LANE_W-1], lane_a} + {lane_b[LANE_W-1], lane_b};
            if (lane_sum[LANE_W] != lane_sum[LANE_W-1]) begin
                sum_c[i*LANE_W +: LANE_W] = lane_sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                             : {1'b0, {(LANE_W-1){1'b1}}};
                clip_c = clip_c + CW'(1);
            end else begin
                sum_c[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
            end
        end
    end

    assign sat_sum_c = {1'b0, sat_count_q} + (CNT_W+1)'(clip_q);

    // Datapath, counters and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_bin_q  <= '0;
            hold_data_q <= '0;
            sum_q       <= '0;
            clip_q      <= '0;
            s_ready_q   <= 1'b1;
            set_zero_q  <= 1'b0;
            r_req_q     <= 1'b0;
            w_req_q     <= 1'b0;
            busy_q      <= 1'b0;
            acc_count_q <= '0;
            sat_count_q <= '0;
        end else begin
            s_ready_q  <= (state_d == IDLE) && !clr;
            set_zero_q <= clr;
            r_req_q    <= (state_d == LOOKUP) || (state_d == WRITE);
            w_req_q    <= (state_d == WRITE);
            busy_q     <= (state_d != IDLE);
            if (accept_c) begin
                hold_bin_q  <= bus.s_bin;
                hold_data_q <= bus.s_data;
            end
            if (load_sum_c) begin
                sum_q  <= sum_c;
                clip_q <= clip_c;
            end
            if (clr) begin
                acc_count_q <= '0;
                sat_count_q <= '0;
            end else if (state_q == WRITE) begin
                acc_count_q <= acc_count_q + CNT_W'(1);
                sat_count_q <= sat_sum_c[CNT_W] ? {CNT_W{1'b1}} : sat_sum_c[CNT_W-1:0];
            end
        end
    end

    // Read and write share the held bin so the write lands on the hot line
    assign bus.s_ready        = s_ready_q;
    assign bus.cache_set_zero = set_zero_q;
    assign bus.cache_r_req    = r_req_q;
    assign bus.cache_r_addr   = hold_bin_q;
    assign bus.cache_w_req    = w_req_q;
    assign bus.cache_w_addr   = hold_bin_q;
    assign bus.cache_w_data   = sum_q;
    assign busy               = busy_q;
    assign acc_count          = acc_count_q;
    assign sat_count          = sat_count_q;
endmodule

// File: tb/tb_fixp_acc_engine.sv
// Directed and random checks of fixp_acc_engine against a one-hot-line cache model
// and a saturating per-bin scoreboard.
module tb_fixp_acc_engine;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned N_RAND = 10000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        busy;
    logic [31:0] acc_count, sat_count;

    fixp_acc_engine_if #(.AW(AW), .DATA_W(DATA_W)) bus();

    fixp_acc_engine #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .bus       (bus),
        .busy      (busy),
        .acc_count (acc_count),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    // Cache model: one hot line, misses fetched after fetch_lat cycles with w_ready low
    logic [DATA_W-1:0] mem [DEPTH];
    logic              hot_v;
    logic [AW-1:0]     hot_a;
    logic [DATA_W-1:0] hot_d;
    logic              fetching;
    logic [AW-1:0]     f_a;
    int                fcnt;
    int                fetch_lat = 1;

    assign bus.cache_req_hit = hot_v && (hot_a == bus.cache_r_addr);
    assign bus.cache_r_data  = hot_d;
    assign bus.cache_w_ready = !fetching;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            hot_v <= 1'b0; hot_a <= '0; hot_d <= '0;
            fetching <= 1'b0; f_a <= '0; fcnt <= 0;
        end else if (bus.cache_set_zero) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            hot_d <= '0;
            fetching <= 1'b0;
        end else if (fetching) begin
            if (fcnt <= 1) begin
                if (hot_v) mem[hot_a] <= hot_d;
                hot_a <= f_a;
                hot_d <= mem[f_a];
                hot_v <= 1'b1;
                fetching <= 1'b0;
            end else begin
                fcnt <= fcnt - 1;
            end
        end else begin
            if (bus.cache_r_req && !bus.cache_req_hit) begin
                fetching <= 1'b1;
                f_a <= bus.cache_r_addr;
                fcnt <= fetch_lat;
            end
            if (bus.cache_w_req && bus.cache_r_req && bus.cache_req_hit) hot_d <= bus.cache_w_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A write must always ride on a read so it targets the hot line
    always @(negedge clk) begin
        if (rstn && bus.cache_w_req === 1'b1) check("wreq_needs_rreq", bus.cache_r_req, 1'b1);
    end

    function automatic logic [127:0] vec4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [127:0] bin_val(input int b);
        if (hot_v && hot_a == AW'(b)) return hot_d;
        return mem[b];
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            output int clipped);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        clipped = 0;
        if (s > 64'sd2147483647) begin
            clipped = 1;
            return 32'h7FFF_FFFF;
        end
        if (s < -64'sd2147483648) begin
            clipped = 1;
            return 32'h8000_0000;
        end
        return 32'(s);
    endfunction

    task automatic send(input logic [AW-1:0] bin, input logic [DATA_W-1:0] data);
        int n = 0;
        while (bus.s_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.s_ready !== 1'b1) begin
            check("send_timeout", bus.s_ready, 1'b1);
            return;
        end
        bus.s_valid = 1'b1;
        bus.s_bin   = bin;
        bus.s_data  = data;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || bus.s_ready !== 1'b1) && n < 300);
        if (busy !== 1'b0) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    logic [DATA_W-1:0] sb [DEPTH];
    logic [31:0]       sat_exp;
    logic [DATA_W-1:0] d;
    logic [31:0]       lane;
    logic [AW-1:0]     rbin;
    int                n, c;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_bin   = '0;
        bus.s_data  = '0;

        // 1. reset
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_acc", acc_count, 32'd0);
        check("rst_sat", sat_count, 32'd0);
        check("rst_r_req", bus.cache_r_req, 1'b0);
        check("rst_w_req", bus.cache_w_req, 1'b0);
        check("rst_set_zero", bus.cache_set_zero, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // 2. hit accumulate, 3 cycles per sample once hot
        send(5'd3, vec4(1, 2, 3, 4));
        wait_idle(n);
        send(5'd3, vec4(1, 2, 3, 4));
        wait_idle(n);
        check("hot_cycles", 128'(n), 128'd3);
        check("hit_bin3", bin_val(3), vec4(2, 4, 6, 8));
        check("hit_acc", acc_count, 32'd2);
        check("hit_sat", sat_count, 32'd0);

        // clr together with s_valid: clr wins, one-cycle set_zero, s_ready low meanwhile
        @(negedge clk);
        clr = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_bin = 5'd9;
        bus.s_data = vec4(1, 1, 1, 1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("clr_set_zero", bus.cache_set_zero, 1'b1);
        check("clr_s_ready", bus.s_ready, 1'b0);
        check("clr_busy", busy, 1'b0);
        check("clr_acc", acc_count, 32'd0);
        @(negedge clk);
        check("clr_set_zero_end", bus.cache_set_zero, 1'b0);
        check("clr_s_ready_back", bus.s_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("clr_no_sample", acc_count, 32'd0);
        check("clr_bin9", bin_val(9), 128'd0);
        check("clr_bin3", bin_val(3), 128'd0);

        // 3. miss then hit, LOOKUP waits out a 4-cycle fetch
        fetch_lat = 4;
        send(5'd3, vec4(1, 1, 1, 1));
        wait_idle(n);
        send(5'd7, vec4(5, 5, 5, 5));
        wait_idle(n);
        check("miss_cycles", 128'(n), 128'd8);
        send(5'd3, vec4(1, 1, 1, 1));
        wait_idle(n);
        check("mh_bin3", bin_val(3), vec4(2, 2, 2, 2));
        check("mh_bin7", bin_val(7), vec4(5, 5, 5, 5));
        check("mh_acc", acc_count, 32'd3);

        // 4. saturation at both rails
        fetch_lat = 1;
        send(5'd5, vec4(32'h7FFF_FFF0, 32'h8000_0001, 0, 0));
        wait_idle(n);
        check("sat_pre_sat", sat_count, 32'd0);
        send(5'd5, vec4(32'h0000_0020, 32'hFFFF_FFF0, 0, 0));
        wait_idle(n);
        check("sat_bin5", bin_val(5), vec4(32'h7FFF_FFFF, 32'h8000_0000, 0, 0));
        check("sat_count", sat_count, 32'd2);
        check("sat_acc", acc_count, 32'd5);

        // 5. clr during a miss in LOOKUP
        fetch_lat = 6;
        send(5'd20, vec4(1, 1, 1, 1));
        @(negedge clk);
        @(negedge clk);
        check("midclr_busy_pre", busy, 1'b1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("midclr_set_zero", bus.cache_set_zero, 1'b1);
        check("midclr_busy", busy, 1'b0);
        check("midclr_r_req", bus.cache_r_req, 1'b0);
        check("midclr_acc", acc_count, 32'd0);
        check("midclr_sat", sat_count, 32'd0);
        @(negedge clk);
        check("midclr_set_zero_end", bus.cache_set_zero, 1'b0);
        fetch_lat = 1;
        send(5'd20, vec4(9, 9, 9, 9));
        wait_idle(n);
        check("midclr_bin20", bin_val(20), vec4(9, 9, 9, 9));
        check("midclr_bin5", bin_val(5), 128'd0);
        check("midclr_acc1", acc_count, 32'd1);

        // 6. random stream vs. saturating scoreboard
        pulse_clr();
        @(negedge clk);
        for (int b = 0; b < DEPTH; b++) sb[b] = '0;
        sat_exp = '0;
        rbin = '0;
        for (int i = 0; i < N_RAND; i++) begin
            if ($urandom_range(0, 1) == 0) rbin = AW'($urandom_range(0, DEPTH - 1));
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 3) == 0) lane = $urandom;
                else lane = 32'($urandom_range(0, 2000)) - 32'd1000;
                d[l*32 +: 32] = lane;
                sb[rbin][l*32 +: 32] = sat_add(sb[rbin][l*32 +: 32], lane, c);
                sat_exp = sat_exp + 32'(c);
            end
            send(rbin, d);
        end
        wait_idle(n);
        for (int b = 0; b < DEPTH; b++) begin
            check($sformatf("rand_bin%0d", b), bin_val(b), sb[b]);
        end
        check("rand_acc", acc_count, 32'(N_RAND));
        check("rand_sat", sat_count, sat_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
